alu_rr_sequencer: RTL and testbench

Two-requester round-robin arbiter and sequencer that shares a single registered ALU datapath (WIDTH-bit signed operands, WIDTH+1-bit result) between two independent clients. It accepts operation requests on valid/ready handshakes and issues one operation at a time to the ALU with the enable/opcode controls. It captures the ALU result one cycle after issue and returns it to the originating requester on a valid/ready response channel. It sits between the test/host logic and the ALU instance in the datapath top.

---
 rtl/alu_rr_sequencer_if.sv | 56 +++++
 rtl/alu_rr_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_rr_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_sequencer_if.sv
// Request, response and ALU-control signals for the two-client ALU sequencer.
// slave is the sequencer's view; master is the host/ALU side.
interface alu_rr_sequencer_if #(
  parameter int WIDTH = 5,
  parameter int OPW   = 3,
  parameter int BPW   = 2
);
  logic                    req0_valid;
  logic                    req0_ready;
  logic signed [WIDTH-1:0] req0_a;
  logic signed [WIDTH-1:0] req0_b;
  logic [1:0]              req0_mode;
  logic [OPW-1:0]          req0_a_op;
  logic [BPW-1:0]          req0_b_op;

  logic                    req1_valid;
  logic                    req1_ready;
  logic signed [WIDTH-1:0] req1_a;
  logic signed [WIDTH-1:0] req1_b;
  logic [1:0]              req1_mode;
  logic [OPW-1:0]          req1_a_op;
  logic [BPW-1:0]          req1_b_op;

  logic                    rsp0_valid;
  logic                    rsp0_ready;
  logic                    rsp1_valid;
  logic                    rsp1_ready;
  logic signed [WIDTH:0]   rsp_data;

  logic                    alu_en;
  logic                    alu_a_en;
  logic                    alu_b_en;
  logic [OPW-1:0]          alu_a_op;
  logic [BPW-1:0]          alu_b_op;
  logic signed [WIDTH-1:0] alu_a;
  logic signed [WIDTH-1:0] alu_b;
  logic signed [WIDTH:0]   alu_c;

  logic                    busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_mode, req0_a_op, req0_b_op,
    input  req1_valid, req1_a, req1_b, req1_mode, req1_a_op, req1_b_op,
    input  rsp0_ready, rsp1_ready, alu_c,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    output alu_en, alu_a_en, alu_b_en, alu_a_op, alu_b_op, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_mode, req0_a_op, req0_b_op,
    output req1_valid, req1_a, req1_b, req1_mode, req1_a_op, req1_b_op,
    output rsp0_ready, rsp1_ready, alu_c,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    input  alu_en, alu_a_en, alu_b_en, alu_a_op, alu_b_op, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one registered ALU between two requesters.
//   state   | meaning
//   IDLE    | waiting for a request; grants one and latches its payload
//   ISSUE   | ALU enabled with the latched operands/opcodes
//   CAPTURE | ALU result valid; copied into rsp_data on the edge
//   RESP    | response held for the granted requester until it takes it
module alu_rr_sequencer #(
  parameter int WIDTH = 5,
  parameter int OPW   = 3,
  parameter int BPW   = 2
) (
  input logic               clk,
  input logic               rst,
  alu_rr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t                  state;
  logic                    rr_ptr;
  logic                    grant_id;
  logic                    grant_sel;
  logic                    req_any;
  logic                    rsp_take;

  logic                    alu_en_q;
  logic                    alu_a_en_q;
  logic                    alu_b_en_q;
  logic [OPW-1:0]          alu_a_op_q;
  logic [BPW-1:0]          alu_b_op_q;
  logic signed [WIDTH-1:0] alu_a_q;
  logic signed [WIDTH-1:0] alu_b_q;
  logic signed [WIDTH:0]   rsp_data_q;
  logic                    rsp0_valid_q;
  logic                    rsp1_valid_q;
  logic                    busy_q;

  // Requester 1 wins when it is the only one asking, or when both ask and it is its turn.
  always_comb begin
    req_any   = bus.req0_valid | bus.req1_valid;
    grant_sel = bus.req1_valid & (~bus.req0_valid | rr_ptr);
    rsp_take  = grant_id ? bus.rsp1_ready : bus.rsp0_ready;
  end

  assign bus.req0_ready = (state == IDLE) & ~rst & bus.req0_valid & ~grant_sel;
  assign bus.req1_ready = (state == IDLE) & ~rst & grant_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      grant_id     <= 1'b0;
      alu_en_q     <= 1'b0;
      alu_a_en_q   <= 1'b0;
      alu_b_en_q   <= 1'b0;
      alu_a_op_q   <= '0;
      alu_b_op_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_data_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant_id <= grant_sel;
            rr_ptr   <= ~grant_sel;
            alu_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= ISSUE;
            if (grant_sel) begin
              alu_a_en_q <= bus.req1_mode[1];
              alu_b_en_q <= bus.req1_mode[0];
              alu_a_op_q <= bus.req1_a_op;
              alu_b_op_q <= bus.req1_b_op;
              alu_a_q    <= bus.req1_a;
              alu_b_q    <= bus.req1_b;
            end else begin
              alu_a_en_q <= bus.req0_mode[1];
              alu_b_en_q <= bus.req0_mode[0];
              alu_a_op_q <= bus.req0_a_op;
              alu_b_op_q <= bus.req0_b_op;
              alu_a_q    <= bus.req0_a;
              alu_b_q    <= bus.req0_b;
            end
          end
        end
        ISSUE: begin
          alu_en_q   <= 1'b0;
          alu_a_en_q <= 1'b0;
          alu_b_en_q <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data_q   <= bus.alu_c;
          rsp0_valid_q <= ~grant_id;
          rsp1_valid_q <= grant_id;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_en     = alu_en_q;
  assign bus.alu_a_en   = alu_a_en_q;
  assign bus.alu_b_en   = alu_b_en_q;
  assign bus.alu_a_op   = alu_a_op_q;
  assign bus.alu_b_op   = alu_b_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer with a small registered ALU model on alu_c.
module tb_alu_rr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_rr_sequencer_if #(.WIDTH(5), .OPW(3), .BPW(2)) bus ();

  alu_rr_sequencer #(.WIDTH(5), .OPW(3), .BPW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ALU model: a_en adds, b_en subtracts, result cleared whenever not enabled
  always @(posedge clk or posedge rst) begin
    if (rst) bus.alu_c <= '0;
    else if (bus.alu_en && bus.alu_a_en) bus.alu_c <= {bus.alu_a[4], bus.alu_a} + {bus.alu_b[4], bus.alu_b};
    else if (bus.alu_en && bus.alu_b_en) bus.alu_c <= {bus.alu_a[4], bus.alu_a} - {bus.alu_b[4], bus.alu_b};
    else bus.alu_c <= '0;
  end

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_mode = '0;
    bus.req0_a_op = '0; bus.req0_b_op = '0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_mode = '0;
    bus.req1_a_op = '0; bus.req1_b_op = '0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.alu_en, bus.alu_a_en, bus.alu_b_en, bus.busy, bus.rsp0_valid, bus.rsp1_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000",
        {bus.alu_en, bus.alu_a_en, bus.alu_b_en, bus.busy, bus.rsp0_valid, bus.rsp1_valid});
    end
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_a_op, bus.alu_b_op, bus.rsp_data} !== 21'b0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0",
        {bus.alu_a, bus.alu_b, bus.alu_a_op, bus.alu_b_op, bus.rsp_data});
    end
    bus.req0_valid = 1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b required 0", bus.req0_ready);
    end
    bus.req0_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.alu_en !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_quiet: cycle %0d alu_en=%b busy=%b required 0 0", i, bus.alu_en, bus.busy);
      end
    end
  endtask

  task automatic test_single_op();
    bus.req0_a = 5'sd7; bus.req0_b = -5'sd3; bus.req0_mode = 2'b10;
    bus.req0_a_op = 3'd0; bus.req0_b_op = 2'd0; bus.req0_valid = 1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready: got %b%b required 10", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready_pulse: got %b required 0", bus.req0_ready);
    end
    bus.req0_valid = 0;
    n_checks++;
    if (bus.alu_en !== 1'b1 || bus.alu_a_en !== 1'b1 || bus.alu_b_en !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL single_issue_ctrl: got en=%b a_en=%b b_en=%b busy=%b required 1 1 0 1",
        bus.alu_en, bus.alu_a_en, bus.alu_b_en, bus.busy);
    end
    n_checks++;
    if (bus.alu_a !== 5'sd7 || bus.alu_b !== -5'sd3) begin
      n_fail++; $display("FAIL single_issue_ops: got a=%0d b=%0d required 7 -3", bus.alu_a, bus.alu_b);
    end
    @(negedge clk);
    n_checks++;
    if (bus.alu_en !== 1'b0 || bus.alu_a_en !== 1'b0 || bus.alu_a !== 5'sd7 || bus.rsp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_capture: got en=%b a_en=%b a=%0d rsp0_valid=%b required 0 0 7 0",
        bus.alu_en, bus.alu_a_en, bus.alu_a, bus.rsp0_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp_data !== 6'sd4) begin
      n_fail++; $display("FAIL single_resp: got v0=%b v1=%b data=%0d required 1 0 4",
        bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data);
    end
    bus.rsp0_ready = 1;
    @(negedge clk);
    n_checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got v0=%b busy=%b required 0 0", bus.rsp0_valid, bus.busy);
    end
    bus.rsp0_ready = 0;
  endtask

  task automatic test_contention();
    logic g;
    do_reset();
    bus.req0_a = 5'sd1;  bus.req0_b = 5'sd2; bus.req0_mode = 2'b10;
    bus.req1_a = -5'sd4; bus.req1_b = 5'sd5; bus.req1_mode = 2'b01;
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      g = (i % 2) == 1;
      #1;
      n_checks++;
      if (bus.req0_ready !== ~g || bus.req1_ready !== g) begin
        n_fail++; $display("FAIL contention_grant: op %0d got %b%b required %b%b", i,
          bus.req0_ready, bus.req1_ready, ~g, g);
      end
      @(negedge clk);
      n_checks++;
      if (bus.alu_a_en !== ~g || bus.alu_b_en !== g || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL contention_issue: op %0d got a_en=%b b_en=%b rdy=%b%b", i,
          bus.alu_a_en, bus.alu_b_en, bus.req0_ready, bus.req1_ready);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.rsp0_valid !== ~g || bus.rsp1_valid !== g || bus.rsp_data !== (g ? -6'sd9 : 6'sd3)) begin
        n_fail++; $display("FAIL contention_resp: op %0d got v0=%b v1=%b data=%0d required %b %b %0d", i,
          bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, ~g, g, g ? -9 : 3);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    bus.rsp0_ready = 1; bus.rsp1_ready = 0;
    bus.req1_a = 5'sd10; bus.req1_b = 5'sd3; bus.req1_mode = 2'b01; bus.req1_valid = 1;
    #1;
    n_checks++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_grant: got %b%b required 01", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    bus.req1_valid = 0;
    bus.req0_a = 5'sd1; bus.req0_b = 5'sd1; bus.req0_mode = 2'b10; bus.req0_valid = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 6'sd7 ||
          bus.req0_ready !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d got v1=%b v0=%b data=%0d rdy0=%b busy=%b required 1 0 7 0 1",
          k, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, bus.req0_ready, bus.busy);
      end
      if (k == 4) bus.rsp1_ready = 1;
      @(negedge clk);
    end
    n_checks++;
    if (bus.rsp1_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got v1=%b busy=%b rdy0=%b required 0 0 1",
        bus.rsp1_valid, bus.busy, bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 0; bus.rsp1_ready = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 6'sd2) begin
      n_fail++; $display("FAIL bp_next_op: got v0=%b data=%0d required 1 2", bus.rsp0_valid, bus.rsp_data);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_payload_change();
    bus.rsp0_ready = 1;
    bus.req0_a = 5'sd3; bus.req0_b = 5'sd1; bus.req0_mode = 2'b10; bus.req0_valid = 1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL payload_grant: got %b required 1", bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_a = 5'sd9; bus.req0_valid = 0;
    #1;
    n_checks++;
    if (bus.alu_a !== 5'sd3 || bus.alu_b !== 5'sd1) begin
      n_fail++; $display("FAIL payload_latch: got a=%0d b=%0d required 3 1", bus.alu_a, bus.alu_b);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 6'sd4) begin
      n_fail++; $display("FAIL payload_result: got v0=%b data=%0d required 1 4", bus.rsp0_valid, bus.rsp_data);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid_op();
    // req0 accepted leaves rr_ptr=1; the reset must bring it back to 0
    bus.req0_a = 5'sd3; bus.req0_b = 5'sd2; bus.req0_mode = 2'b10; bus.req0_valid = 1;
    @(negedge clk);
    bus.req0_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.alu_a !== 5'sd0 || bus.busy !== 1'b0 || bus.alu_en !== 1'b0 || bus.rsp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset: got a=%0d busy=%b en=%b v0=%b required 0 0 0 0",
        bus.alu_a, bus.busy, bus.alu_en, bus.rsp0_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL midop_no_resp: cycle %0d got v0=%b busy=%b required 0 0", i, bus.rsp0_valid, bus.busy);
      end
    end
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL midop_rr_ptr: got %b%b required 10", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    bus.req0_valid = 0; bus.req1_valid = 0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.alu_en !== 1'b0 || bus.alu_a_en !== 1'b0) begin
      n_fail++; $display("FAIL issue_reset: got en=%b a_en=%b required 0 0", bus.alu_en, bus.alu_a_en);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_payload_change();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
